pipe5_memory_stage: RTL and testbench

- Fourth stage of the five-stage pipeline. Sits between execute and writeback.
- Issues data-bus loads and stores and waits on the bus handshake. Sign/zero-extends load data.
- Registers all register-file and FP-register-file write-back fields into the memory/writeback pipeline register consumed by writeback.
- Asserts a stall to the hazard unit while a bus access is outstanding.

---
 rtl/rv32i_types_pkg.sv | 63 ++++++
 rtl/pipe5_load_ext.sv | 29 ++
 rtl/pipe5_memory_stage.sv | 216 +++++++++++++++++++++
 tb/tb_pipe5_memory_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32 pipeline types: load sizes, write-back select encodings,
// memory-stage FSM states and the byte-lane helpers used by both the
// store byte-enable path and the load extension path.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    // funct3 of loads/stores; bits [1:0] give the access size
    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_t;

    typedef enum logic [2:0] {
        W_SEL_LOAD  = 3'd0,
        W_SEL_WDATA = 3'd1,
        W_SEL_ALU   = 3'd3,
        W_SEL_CSR   = 3'd4
    } w_sel_t;

    typedef enum logic [1:0] {
        F_WSEL_FPU   = 2'd0,
        F_WSEL_LOAD  = 2'd1,
        F_WSEL_WDATA = 2'd2
    } f_wsel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Bit offset of a byte lane within a bus word
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

    // Byte enables for an access of the given size (0 byte, 1 half, else word)
    function automatic logic [3:0] lane_byte_en(input logic [1:0] size,
                                                input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lane);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lane[0];
            default: bad = (lane != 2'd0);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/pipe5_load_ext.sv
// Load data extraction: selects the addressed byte/halfword from the bus
// word and sign- or zero-extends it according to the load funct3.
//   rdata   : raw bus read data
//   ld_type : funct3 (LB/LH/LW/LBU/LHU)
//   lane    : address bits [1:0]
//   ext     : extended load result
module pipe5_load_ext
    import rv32i_types_pkg::*;
(
    input  word_t       rdata,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  lane,
    output word_t       ext
);

    word_t shifted;

    always_comb begin
        shifted = rdata >> lane_shift(lane);
        case (load_t'(ld_type))
            LB:      ext = {{24{shifted[7]}}, shifted[7:0]};
            LH:      ext = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     ext = {24'd0, shifted[7:0]};
            LHU:     ext = {16'd0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

endmodule

// File: rtl/pipe5_memory_stage.sv
// Memory stage of the five-stage pipeline. Issues data-bus loads/stores,
// waits on dbus_busy, extends load data and registers every write-back
// field into the memory/writeback pipeline register.
//   CLK, RST        : clock, synchronous active-high reset
//   ex_*            : execute/memory pipeline register contents
//   flush           : squash the instruction in this stage
//   dbus_*          : data-bus request/response
//   mem_stall       : hold upstream while a bus access is outstanding
//   misaligned      : one-cycle pulse for a trapped misaligned access
//   wb_*            : memory/writeback pipeline register
module pipe5_memory_stage
    import rv32i_types_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ex_valid,
    input  logic                ex_ren,
    input  logic                ex_wen_mem,
    input  logic [2:0]          ex_ld_type,
    input  logic [DATA_W-1:0]   ex_alu_out,
    input  logic [DATA_W-1:0]   ex_store_data,
    input  logic [DATA_W-1:0]   ex_csr_rdata,
    input  logic [DATA_W-1:0]   ex_reg_wdata,
    input  logic                ex_wen,
    input  logic [4:0]          ex_reg_rd,
    input  logic [2:0]          ex_w_sel,
    input  logic                ex_f_wen,
    input  logic [1:0]          ex_f_wsel,
    input  logic [4:0]          ex_f_reg_rd,
    input  logic [DATA_W-1:0]   ex_fpu_out,
    input  logic [DATA_W-1:0]   ex_f_wdata,
    input  logic                flush,
    output logic [ADDR_W-1:0]   dbus_addr,
    output logic                dbus_ren,
    output logic                dbus_wen,
    output logic [DATA_W-1:0]   dbus_wdata,
    output logic [3:0]          dbus_byte_en,
    input  logic                dbus_busy,
    input  logic [DATA_W-1:0]   dbus_rdata,
    output logic                mem_stall,
    output logic                misaligned,
    output logic                wb_wen,
    output logic [4:0]          wb_reg_rd,
    output logic [2:0]          wb_w_sel,
    output logic [DATA_W-1:0]   wb_alu_port_out,
    output logic [DATA_W-1:0]   wb_dload_ext,
    output logic [DATA_W-1:0]   wb_csr_rdata,
    output logic [DATA_W-1:0]   wb_reg_file_wdata,
    output logic                wb_f_wen,
    output logic [1:0]          wb_f_wsel,
    output logic [4:0]          wb_f_reg_rd,
    output logic [DATA_W-1:0]   wb_fpu_out,
    output logic [DATA_W-1:0]   wb_f_wdata
);

    mem_state_t         state_q, state_d;
    logic               flush_q;

    // Request latched on entry to WAIT so it stays stable even if the
    // upstream register changes after a flush.
    logic               req_ren_q, req_wen_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic [DATA_W-1:0]  req_wdata_q;
    logic [3:0]         req_be_q;
    logic [2:0]         req_type_q;
    logic [1:0]         req_lane_q;

    logic [1:0]         lane, size;
    logic               mem_op, mis, issue, kill;
    logic [DATA_W-1:0]  store_rep;
    logic [2:0]         ext_type;
    logic [1:0]         ext_lane;
    word_t              dload_ext;

    assign lane   = ex_alu_out[1:0];
    assign size   = ex_ld_type[1:0];
    assign mem_op = ex_valid & (ex_ren | ex_wen_mem);
    assign mis    = mem_op & is_misaligned(size, lane);
    assign issue  = mem_op & ~mis & ~flush;

    always_comb begin
        case (size)
            2'd0:    store_rep = {4{ex_store_data[7:0]}};
            2'd1:    store_rep = {2{ex_store_data[15:0]}};
            default: store_rep = ex_store_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dbus_ren     = 1'b0;
        dbus_wen     = 1'b0;
        dbus_addr    = '0;
        dbus_wdata   = '0;
        dbus_byte_en = '0;
        ext_type     = ex_ld_type;
        ext_lane     = lane;
        kill         = flush | mis;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    dbus_ren     = ex_ren;
                    dbus_wen     = ex_wen_mem & ~ex_ren;
                    dbus_addr    = {ex_alu_out[ADDR_W-1:2], 2'b00};
                    dbus_wdata   = (ex_wen_mem & ~ex_ren) ? store_rep : '0;
                    dbus_byte_en = lane_byte_en(size, lane);
                    // busy low in the first request cycle completes here
                    if (dbus_busy) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                dbus_ren     = req_ren_q;
                dbus_wen     = req_wen_q;
                dbus_addr    = req_addr_q;
                dbus_wdata   = req_wdata_q;
                dbus_byte_en = req_be_q;
                ext_type     = req_type_q;
                ext_lane     = req_lane_q;
                kill         = flush_q | flush;
                if (!dbus_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (RST) begin
            state_d      = IDLE;
            dbus_ren     = 1'b0;
            dbus_wen     = 1'b0;
            dbus_addr    = '0;
            dbus_wdata   = '0;
            dbus_byte_en = '0;
        end
    end

    assign mem_stall = (dbus_ren | dbus_wen) & dbus_busy;

    pipe5_load_ext u_load_ext (
        .rdata   (dbus_rdata),
        .ld_type (ext_type),
        .lane    (ext_lane),
        .ext     (dload_ext)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            flush_q     <= 1'b0;
            req_ren_q   <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            req_type_q  <= '0;
            req_lane_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == WAIT) begin
                req_ren_q   <= dbus_ren;
                req_wen_q   <= dbus_wen;
                req_addr_q  <= dbus_addr;
                req_wdata_q <= dbus_wdata;
                req_be_q    <= dbus_byte_en;
                req_type_q  <= ex_ld_type;
                req_lane_q  <= lane;
            end
            // A flush seen at any point of an outstanding access sticks
            // until the access drains.
            flush_q <= (state_q == WAIT) && (state_d == WAIT) && (flush_q | flush);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            misaligned        <= 1'b0;
            wb_wen            <= 1'b0;
            wb_reg_rd         <= '0;
            wb_w_sel          <= '0;
            wb_alu_port_out   <= '0;
            wb_dload_ext      <= '0;
            wb_csr_rdata      <= '0;
            wb_reg_file_wdata <= '0;
            wb_f_wen          <= 1'b0;
            wb_f_wsel         <= '0;
            wb_f_reg_rd       <= '0;
            wb_fpu_out        <= '0;
            wb_f_wdata        <= '0;
        end else begin
            misaligned <= (state_q == IDLE) & mis & ~flush;
            if (mem_stall) begin
                // bubble so writeback does not replay the previous result
                wb_wen   <= 1'b0;
                wb_f_wen <= 1'b0;
            end else begin
                wb_wen            <= ex_valid & ex_wen & ~kill;
                wb_reg_rd         <= ex_reg_rd;
                wb_w_sel          <= ex_w_sel;
                wb_alu_port_out   <= ex_alu_out;
                wb_dload_ext      <= dload_ext;
                wb_csr_rdata      <= ex_csr_rdata;
                wb_reg_file_wdata <= ex_reg_wdata;
                wb_f_wen          <= ex_valid & ex_f_wen & ~kill;
                wb_f_wsel         <= ex_f_wsel;
                wb_f_reg_rd       <= ex_f_reg_rd;
                wb_fpu_out        <= ex_fpu_out;
                wb_f_wdata        <= ex_f_wdata;
            end
        end
    end

endmodule

// File: tb/tb_pipe5_memory_stage.sv
// Scoreboard bench for pipe5_memory_stage: each driven cycle pushes its
// expected bus/stall values and expected write-back register contents.
module tb_pipe5_memory_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ex_valid, ex_ren, ex_wen_mem, ex_wen, ex_f_wen, flush;
    logic [2:0]  ex_ld_type, ex_w_sel;
    logic [1:0]  ex_f_wsel;
    logic [4:0]  ex_reg_rd, ex_f_reg_rd;
    logic [31:0] ex_alu_out, ex_store_data, ex_csr_rdata, ex_reg_wdata;
    logic [31:0] ex_fpu_out, ex_f_wdata;
    logic        dbus_busy;
    logic [31:0] dbus_rdata;

    logic [31:0] dbus_addr, dbus_wdata;
    logic        dbus_ren, dbus_wen, mem_stall, misaligned;
    logic [3:0]  dbus_byte_en;
    logic        wb_wen, wb_f_wen;
    logic [4:0]  wb_reg_rd, wb_f_reg_rd;
    logic [2:0]  wb_w_sel;
    logic [1:0]  wb_f_wsel;
    logic [31:0] wb_alu_port_out, wb_dload_ext, wb_csr_rdata, wb_reg_file_wdata;
    logic [31:0] wb_fpu_out, wb_f_wdata;

    pipe5_memory_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .ex_valid(ex_valid), .ex_ren(ex_ren), .ex_wen_mem(ex_wen_mem),
        .ex_ld_type(ex_ld_type), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_csr_rdata(ex_csr_rdata),
        .ex_reg_wdata(ex_reg_wdata), .ex_wen(ex_wen), .ex_reg_rd(ex_reg_rd),
        .ex_w_sel(ex_w_sel), .ex_f_wen(ex_f_wen), .ex_f_wsel(ex_f_wsel),
        .ex_f_reg_rd(ex_f_reg_rd), .ex_fpu_out(ex_fpu_out),
        .ex_f_wdata(ex_f_wdata), .flush(flush),
        .dbus_addr(dbus_addr), .dbus_ren(dbus_ren), .dbus_wen(dbus_wen),
        .dbus_wdata(dbus_wdata), .dbus_byte_en(dbus_byte_en),
        .dbus_busy(dbus_busy), .dbus_rdata(dbus_rdata),
        .mem_stall(mem_stall), .misaligned(misaligned),
        .wb_wen(wb_wen), .wb_reg_rd(wb_reg_rd), .wb_w_sel(wb_w_sel),
        .wb_alu_port_out(wb_alu_port_out), .wb_dload_ext(wb_dload_ext),
        .wb_csr_rdata(wb_csr_rdata), .wb_reg_file_wdata(wb_reg_file_wdata),
        .wb_f_wen(wb_f_wen), .wb_f_wsel(wb_f_wsel), .wb_f_reg_rd(wb_f_reg_rd),
        .wb_fpu_out(wb_fpu_out), .wb_f_wdata(wb_f_wdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          pre;
        bit          stall;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          chk_wd;
        logic [31:0] wdata;
        bit          wbw;
        bit          wbf;
        bit          chk_ld;
        logic [31:0] ld;
        bit          mis;
        bit          chk_rd;
        logic [4:0]  rd;
        bit          zero;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, what, act, exp);
        end
    endtask

    function automatic exp_t blank(input string n);
        exp_t e;
        e.pre = 1; e.stall = 0; e.ren = 0; e.wen = 0; e.addr = '0; e.be = '0;
        e.chk_wd = 0; e.wdata = '0; e.wbw = 0; e.wbf = 0; e.chk_ld = 0;
        e.ld = '0; e.mis = 0; e.chk_rd = 0; e.rd = '0; e.zero = 0; e.name = n;
        return e;
    endfunction

    task automatic clr();
        ex_valid = 0; ex_ren = 0; ex_wen_mem = 0; ex_wen = 0; ex_f_wen = 0;
        flush = 0; ex_ld_type = '0; ex_w_sel = '0; ex_f_wsel = '0;
        ex_reg_rd = '0; ex_f_reg_rd = '0; ex_alu_out = '0; ex_store_data = '0;
        ex_csr_rdata = '0; ex_reg_wdata = '0; ex_fpu_out = '0; ex_f_wdata = '0;
        dbus_busy = 0; dbus_rdata = '0;
    endtask

    task automatic step(input exp_t e);
        sb.push_back(e);
        @(negedge CLK);
    endtask

    task automatic set_mem(input bit ld, input logic [2:0] t, input logic [31:0] a);
        clr();
        ex_valid = 1; ex_ren = ld; ex_wen_mem = !ld; ex_ld_type = t; ex_alu_out = a;
    endtask

    // Monitor: compares pre-edge bus/stall, then the post-edge wb register
    initial begin
        exp_t e;
        bit   have;
        forever begin
            @(negedge CLK);
            #2;
            have = 0;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                have = 1;
                if (e.pre) begin
                    chk(e.name, "mem_stall", 32'(mem_stall), 32'(e.stall));
                    chk(e.name, "dbus_ren", 32'(dbus_ren), 32'(e.ren));
                    chk(e.name, "dbus_wen", 32'(dbus_wen), 32'(e.wen));
                    if (e.ren || e.wen) begin
                        chk(e.name, "dbus_addr", dbus_addr, e.addr);
                        chk(e.name, "byte_en", 32'(dbus_byte_en), 32'(e.be));
                    end
                    if (e.chk_wd) chk(e.name, "dbus_wdata", dbus_wdata, e.wdata);
                end
            end
            @(posedge CLK);
            #1;
            if (have) begin
                chk(e.name, "wb_wen", 32'(wb_wen), 32'(e.wbw));
                chk(e.name, "wb_f_wen", 32'(wb_f_wen), 32'(e.wbf));
                chk(e.name, "misaligned", 32'(misaligned), 32'(e.mis));
                if (e.chk_ld) chk(e.name, "wb_dload_ext", wb_dload_ext, e.ld);
                if (e.chk_rd) chk(e.name, "wb_reg_rd", 32'(wb_reg_rd), 32'(e.rd));
                if (e.zero)
                    chk(e.name, "all_outputs_zero",
                        32'(|{wb_wen, wb_reg_rd, wb_w_sel, wb_alu_port_out, wb_dload_ext,
                              wb_csr_rdata, wb_reg_file_wdata, wb_f_wen, wb_f_wsel,
                              wb_f_reg_rd, wb_fpu_out, wb_f_wdata, misaligned,
                              mem_stall, dbus_ren, dbus_wen, dbus_addr, dbus_wdata,
                              dbus_byte_en}), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        clr();
        RST = 1;
        @(negedge CLK);
        e = blank("reset0"); e.zero = 1; step(e);
        e = blank("reset1"); e.zero = 1; step(e);
        RST = 0;

        clr();
        e = blank("idle"); step(e);

        clr(); ex_valid = 1; ex_wen = 1; ex_reg_rd = 5'd5; ex_w_sel = 3'd3;
        ex_alu_out = 32'h0000_1234;
        e = blank("alu"); e.wbw = 1; e.chk_rd = 1; e.rd = 5'd5; step(e);

        clr(); ex_wen = 1; ex_reg_rd = 5'd6;
        e = blank("invalid"); step(e);

        set_mem(1, 3'd0, 32'h0000_1003); ex_wen = 1; ex_reg_rd = 5'd7;
        dbus_rdata = 32'h80FF_0000;
        e = blank("lb"); e.ren = 1; e.addr = 32'h0000_1000; e.be = 4'b1000;
        e.wbw = 1; e.chk_ld = 1; e.ld = 32'hFFFF_FF80; e.chk_rd = 1; e.rd = 5'd7;
        step(e);

        set_mem(1, 3'd5, 32'h0000_2002); ex_wen = 1; ex_reg_rd = 5'd8;
        dbus_busy = 1; dbus_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            e = blank("lhu_wait"); e.stall = 1; e.ren = 1;
            e.addr = 32'h0000_2000; e.be = 4'b1100; step(e);
        end
        dbus_busy = 0; dbus_rdata = 32'h8001_1234;
        e = blank("lhu_done"); e.ren = 1; e.addr = 32'h0000_2000; e.be = 4'b1100;
        e.wbw = 1; e.chk_ld = 1; e.ld = 32'h0000_8001; e.chk_rd = 1; e.rd = 5'd8;
        step(e);

        set_mem(0, 3'd0, 32'h0000_3001); ex_store_data = 32'h0000_00AB;
        e = blank("sb"); e.wen = 1; e.addr = 32'h0000_3000; e.be = 4'b0010;
        e.chk_wd = 1; e.wdata = 32'hABAB_ABAB; step(e);

        set_mem(0, 3'd1, 32'h0000_300A); ex_store_data = 32'h1234_5678;
        e = blank("sh"); e.wen = 1; e.addr = 32'h0000_3008; e.be = 4'b1100;
        e.chk_wd = 1; e.wdata = 32'h5678_5678; step(e);

        set_mem(0, 3'd2, 32'h0000_3010); ex_store_data = 32'hCAFE_F00D;
        e = blank("sw"); e.wen = 1; e.addr = 32'h0000_3010; e.be = 4'b1111;
        e.chk_wd = 1; e.wdata = 32'hCAFE_F00D; step(e);

        set_mem(1, 3'd2, 32'h0000_4002); ex_wen = 1;
        e = blank("lw_misaligned"); e.mis = 1; step(e);
        clr();
        e = blank("after_misaligned"); step(e);

        set_mem(1, 3'd1, 32'h0000_5001); ex_wen = 1;
        e = blank("lh_misaligned"); e.mis = 1; step(e);

        set_mem(0, 3'd2, 32'h0000_5003);
        e = blank("sw_misaligned"); e.mis = 1; step(e);

        set_mem(1, 3'd1, 32'h0000_5002); ex_wen = 1; ex_reg_rd = 5'd10;
        dbus_rdata = 32'hFFFE_0000;
        e = blank("lh"); e.ren = 1; e.addr = 32'h0000_5000; e.be = 4'b1100;
        e.wbw = 1; e.chk_ld = 1; e.ld = 32'hFFFF_FFFE; step(e);

        set_mem(1, 3'd2, 32'h0000_5004); ex_f_wen = 1; ex_f_wsel = 2'd1;
        dbus_rdata = 32'h3F80_0000;
        e = blank("flw"); e.ren = 1; e.addr = 32'h0000_5004; e.be = 4'b1111;
        e.wbf = 1; e.chk_ld = 1; e.ld = 32'h3F80_0000; step(e);

        clr(); ex_valid = 1; ex_wen = 1; ex_reg_rd = 5'd11; flush = 1;
        e = blank("flush_alu"); step(e);

        set_mem(1, 3'd2, 32'h0000_5008); ex_wen = 1; flush = 1;
        e = blank("flush_idle_load"); step(e);

        set_mem(1, 3'd2, 32'h0000_7000); ex_wen = 1; ex_reg_rd = 5'd9;
        dbus_busy = 1;
        e = blank("flush_c1"); e.stall = 1; e.ren = 1; e.addr = 32'h0000_7000;
        e.be = 4'b1111; step(e);
        flush = 1;
        e = blank("flush_c2"); e.stall = 1; e.ren = 1; e.addr = 32'h0000_7000;
        e.be = 4'b1111; step(e);
        flush = 0; ex_alu_out = 32'h0000_7FF0;
        e = blank("flush_c3"); e.stall = 1; e.ren = 1; e.addr = 32'h0000_7000;
        e.be = 4'b1111; step(e);
        dbus_busy = 0; dbus_rdata = 32'h1111_2222;
        e = blank("flush_c4"); e.ren = 1; e.addr = 32'h0000_7000;
        e.be = 4'b1111; step(e);
        clr();
        e = blank("flush_idle"); step(e);

        set_mem(1, 3'd4, 32'h0000_6001); ex_wen = 1; ex_reg_rd = 5'd12;
        dbus_rdata = 32'h0000_9A00;
        e = blank("lbu"); e.ren = 1; e.addr = 32'h0000_6000; e.be = 4'b0010;
        e.wbw = 1; e.chk_ld = 1; e.ld = 32'h0000_009A; e.chk_rd = 1; e.rd = 5'd12;
        step(e);

        set_mem(1, 3'd2, 32'h0000_8000); ex_wen = 1; dbus_busy = 1;
        e = blank("rst_c1"); e.stall = 1; e.ren = 1; e.addr = 32'h0000_8000;
        e.be = 4'b1111; step(e);
        clr(); dbus_busy = 1; RST = 1;
        e = blank("rst_in_wait"); e.pre = 0; e.zero = 1; step(e);
        clr(); RST = 0;
        e = blank("rst_after"); step(e);
        set_mem(1, 3'd2, 32'h0000_8004); ex_wen = 1; ex_reg_rd = 5'd3;
        dbus_rdata = 32'hCAFE_BABE;
        e = blank("lw_after_rst"); e.ren = 1; e.addr = 32'h0000_8004; e.be = 4'b1111;
        e.wbw = 1; e.chk_ld = 1; e.ld = 32'hCAFE_BABE; e.chk_rd = 1; e.rd = 5'd3;
        step(e);

        clr();
        e = blank("tail"); step(e);
        repeat (3) @(negedge CLK);
        chk("end", "scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
